// File: rtl/serial_readout_ctrl.sv
// Readback engine: one parallel read of three coefficient words at a captured
// address, then the 48-bit concatenation is shifted out MSB first on a serial pad.
module serial_readout_ctrl #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 11,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              trigger,
  input  logic              read_external,
  input  logic [ADDR_W-1:0] read_addr,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata0,
  input  logic [DATA_W-1:0] mem_rdata1,
  input  logic [DATA_W-1:0] mem_rdata2,
  output logic              serial_out,
  output logic              serial_valid,
  output logic              busy,
  output logic              done
);

  localparam int FRAME_W = 3 * DATA_W;
  localparam int CNT_W   = $clog2(FRAME_W);
  localparam int WCNT_W  = $clog2(RD_LAT + 1) + 1;

  localparam logic [CNT_W-1:0]  LAST_BIT  = CNT_W'(FRAME_W - 1);
  localparam logic [WCNT_W-1:0] WAIT_LAST = WCNT_W'(RD_LAT);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_SHIFT = 2'd2,
    S_HOLD  = 2'd3
  } state_t;

  state_t              state, state_nxt;
  logic [FRAME_W-1:0]  shift_reg, shift_nxt;
  logic [CNT_W-1:0]    bit_cnt, bit_nxt;
  logic [WCNT_W-1:0]   wait_cnt, wait_nxt;
  logic                rd_en_nxt;
  logic [ADDR_W-1:0]   addr_nxt;
  logic                sout_nxt;
  logic                valid_nxt;
  logic                busy_nxt;
  logic                done_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      mem_rd_en    <= 1'b0;
      mem_addr     <= '0;
      shift_reg    <= '0;
      bit_cnt      <= '0;
      wait_cnt     <= '0;
      serial_out   <= 1'b0;
      serial_valid <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      state        <= state_nxt;
      mem_rd_en    <= rd_en_nxt;
      mem_addr     <= addr_nxt;
      shift_reg    <= shift_nxt;
      bit_cnt      <= bit_nxt;
      wait_cnt     <= wait_nxt;
      serial_out   <= sout_nxt;
      serial_valid <= valid_nxt;
      busy         <= busy_nxt;
      done         <= done_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    rd_en_nxt = 1'b0;
    addr_nxt  = mem_addr;
    shift_nxt = shift_reg;
    bit_nxt   = bit_cnt;
    wait_nxt  = wait_cnt;
    sout_nxt  = serial_out;
    valid_nxt = serial_valid;
    done_nxt  = done;

    case (state)
      S_IDLE: begin
        if (trigger && read_external) begin
          addr_nxt  = read_addr;
          rd_en_nxt = 1'b1;
          wait_nxt  = '0;
          state_nxt = S_WAIT;
        end
      end

      // The strobe edge itself is not counted, so WAIT spans RD_LAT+1 edges
      // and the load lands on the first edge where read data is valid.
      S_WAIT: begin
        if (wait_cnt == WAIT_LAST) begin
          shift_nxt = {mem_rdata0, mem_rdata1, mem_rdata2};
          sout_nxt  = mem_rdata0[DATA_W-1];
          valid_nxt = 1'b1;
          bit_nxt   = '0;
          state_nxt = S_SHIFT;
        end else begin
          wait_nxt = wait_cnt + WCNT_W'(1);
        end
      end

      S_SHIFT: begin
        if (bit_cnt == LAST_BIT) begin
          sout_nxt  = 1'b0;
          valid_nxt = 1'b0;
          done_nxt  = 1'b1;
          state_nxt = S_HOLD;
        end else begin
          shift_nxt = {shift_reg[FRAME_W-2:0], 1'b0};
          sout_nxt  = shift_reg[FRAME_W-2];
          bit_nxt   = bit_cnt + CNT_W'(1);
        end
      end

      S_HOLD: begin
        if (!read_external) begin
          done_nxt  = 1'b0;
          state_nxt = S_IDLE;
        end
      end

      default: state_nxt = S_IDLE;
    endcase

    busy_nxt = (state_nxt != S_IDLE);
  end

endmodule

// File: tb/tb_serial_readout_ctrl.sv
// Directed bench for serial_readout_ctrl: two instances (RD_LAT=1 and RD_LAT=3)
// fed by latency-accurate memory models, outputs observed through a selector.
module tb_serial_readout_ctrl;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 11;
  localparam logic [47:0] JUNK = 48'hDEAD_BEEF_CAFE;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_n, trigger, req, sel;
  logic [ADDR_W-1:0] read_addr;

  logic              rd_en_a, rd_en_b, sout_a, sout_b, valid_a, valid_b;
  logic              busy_a, busy_b, done_a, done_b;
  logic [ADDR_W-1:0] addr_a, addr_b;
  logic [47:0]       pipe_a;
  logic [47:0]       pipe_b [3];
  logic [47:0]       mem [16];

  serial_readout_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .RD_LAT(1)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .trigger(trigger), .read_external(req & ~sel),
    .read_addr(read_addr), .mem_rd_en(rd_en_a), .mem_addr(addr_a),
    .mem_rdata0(pipe_a[47:32]), .mem_rdata1(pipe_a[31:16]), .mem_rdata2(pipe_a[15:0]),
    .serial_out(sout_a), .serial_valid(valid_a), .busy(busy_a), .done(done_a)
  );

  serial_readout_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .RD_LAT(3)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .trigger(trigger), .read_external(req & sel),
    .read_addr(read_addr), .mem_rd_en(rd_en_b), .mem_addr(addr_b),
    .mem_rdata0(pipe_b[2][47:32]), .mem_rdata1(pipe_b[2][31:16]), .mem_rdata2(pipe_b[2][15:0]),
    .serial_out(sout_b), .serial_valid(valid_b), .busy(busy_b), .done(done_b)
  );

  // Read data is only valid for the one cycle matching the strobe's latency.
  always @(posedge clk) pipe_a <= rd_en_a ? mem[addr_a[3:0]] : JUNK;
  always @(posedge clk) begin
    pipe_b[0] <= rd_en_b ? mem[addr_b[3:0]] : JUNK;
    pipe_b[1] <= pipe_b[0];
    pipe_b[2] <= pipe_b[1];
  end

  logic              o_rd_en, o_out, o_valid, o_busy, o_done;
  logic [ADDR_W-1:0] o_addr;
  assign o_rd_en = sel ? rd_en_b : rd_en_a;
  assign o_out   = sel ? sout_b  : sout_a;
  assign o_valid = sel ? valid_b : valid_a;
  assign o_busy  = sel ? busy_b  : busy_a;
  assign o_done  = sel ? done_b  : done_a;
  assign o_addr  = sel ? addr_b  : addr_a;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Called at a negedge with the request already driven; E0 is the next posedge.
  task automatic capture_frame(input string tag, input logic [ADDR_W-1:0] addr,
                               input logic [47:0] exp, input int lat, input int chg_bit);
    int n, strobes, vcnt;
    logic [47:0] got;
    n = 0;
    strobes = 0;
    do begin
      @(negedge clk);
      n++;
      if (o_rd_en) strobes++;
    end while (!o_valid && n < 20);
    check({tag, "_latency"}, n, lat + 2);
    check({tag, "_strobes"}, strobes, 1);
    got  = {47'b0, o_out};
    vcnt = 1;
    for (int k = 1; k < 48; k++) begin
      if (k == chg_bit) read_addr = 11'd9;
      @(negedge clk);
      got = {got[46:0], o_out};
      if (o_valid) vcnt++;
    end
    check({tag, "_frame"}, got, exp);
    check({tag, "_valid_cycles"}, vcnt, 48);
    @(negedge clk);
    check({tag, "_valid_after"}, o_valid, 1'b0);
    check({tag, "_out_after"}, o_out, 1'b0);
    check({tag, "_done"}, o_done, 1'b1);
    check({tag, "_busy"}, o_busy, 1'b1);
    check({tag, "_mem_addr"}, o_addr, addr);
  endtask

  task automatic release_req(input string tag);
    req = 1'b0;
    @(negedge clk);
    check({tag, "_done_clr"}, o_done, 1'b0);
    check({tag, "_busy_clr"}, o_busy, 1'b0);
  endtask

  initial begin
    int cnt_rd, cnt_busy, cnt_valid, cnt_nodone, w;
    rst_n = 1'b0; trigger = 1'b0; req = 1'b0; sel = 1'b0; read_addr = '0;
    for (int i = 0; i < 16; i++) mem[i] = JUNK;

    repeat (3) @(negedge clk);
    check("rst_rd_en", o_rd_en, 1'b0);
    check("rst_mem_addr", o_addr, 0);
    check("rst_out_valid", {o_out, o_valid}, 2'b00);
    check("rst_busy_done", {o_busy, o_done}, 2'b00);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic frame
    mem[5] = 48'h1771_17A4_0019;
    read_addr = 11'd5; trigger = 1'b1; req = 1'b1;
    capture_frame("frame1", 11'd5, 48'h1771_17A4_0019, 1, -1);
    release_req("frame1");

    // Second frame, then request held high: no re-trigger
    mem[5] = 48'h0BBB_178B_1DD5;
    req = 1'b1;
    capture_frame("frame2", 11'd5, 48'h0BBB_178B_1DD5, 1, -1);
    cnt_rd = 0; cnt_valid = 0; cnt_nodone = 0;
    repeat (200) begin
      @(negedge clk);
      if (o_rd_en) cnt_rd++;
      if (o_valid) cnt_valid++;
      if (!o_done) cnt_nodone++;
    end
    check("hold_no_strobe", cnt_rd, 0);
    check("hold_no_valid", cnt_valid, 0);
    check("hold_done_steady", cnt_nodone, 0);
    release_req("frame2");

    // Request without trigger is ignored
    mem[9] = 48'hA5C3_5A3C_F00F;
    trigger = 1'b0; read_addr = 11'd9; req = 1'b1;
    cnt_rd = 0; cnt_busy = 0;
    repeat (20) begin
      @(negedge clk);
      if (o_rd_en) cnt_rd++;
      if (o_busy) cnt_busy++;
    end
    check("notrig_strobe", cnt_rd, 0);
    check("notrig_busy", cnt_busy, 0);
    trigger = 1'b1;
    capture_frame("late_trig", 11'd9, 48'hA5C3_5A3C_F00F, 1, -1);
    release_req("late_trig");

    // read_addr changed mid-frame
    read_addr = 11'd5; req = 1'b1;
    capture_frame("addr_chg", 11'd5, 48'h0BBB_178B_1DD5, 1, 10);
    release_req("addr_chg");

    // Async reset mid-frame
    mem[7] = 48'h3C3C_0FF0_8001;
    read_addr = 11'd5; req = 1'b1;
    w = 0;
    do begin @(negedge clk); w++; end while (!o_valid && w < 20);
    repeat (20) @(negedge clk);
    check("midrst_pre_valid", o_valid, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_out_valid", {o_out, o_valid}, 2'b00);
    check("midrst_busy_done", {o_busy, o_done, o_rd_en}, 3'b000);
    check("midrst_mem_addr", o_addr, 0);
    req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    read_addr = 11'd7; req = 1'b1;
    capture_frame("post_rst", 11'd7, 48'h3C3C_0FF0_8001, 1, -1);
    release_req("post_rst");

    // RD_LAT = 3 instance
    sel = 1'b1;
    mem[5] = 48'h1771_17A4_0019;
    read_addr = 11'd5;
    @(negedge clk);
    req = 1'b1;
    capture_frame("lat3", 11'd5, 48'h1771_17A4_0019, 3, -1);
    release_req("lat3");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
